rotary_cells_valve_seq: RTL and testbench

// - Sequences the 13 pneumatic control lines of the rotary-mixer cell-trap chip.
// - One run: fill the mixer ring from one of 4 inlets (input mux), mix by peristaltic

---
 rtl/rotary_cells_valve_seq.sv | 177 +++++++++++++++++
 tb/tb_rotary_cells_valve_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rotary_cells_valve_seq.sv
// Valve sequencer for the rotary-mixer cell-trap chip: fill, peristaltic mix, deliver, close.
// Define MIX_REVERSE_EN to pump odd-numbered mix rounds in the reverse direction (P5..P0).
module rotary_cells_valve_seq #(
  parameter int FILL_CYC    = 200,
  parameter int STEP_CYC    = 50,
  parameter int DELIVER_CYC = 400,
  parameter int RND_W       = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       inlet_sel,
  input  logic [1:0]       trap_sel,
  input  logic [RND_W-1:0] mix_rounds,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state_o,
  output logic [12:0]      valve
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    MIX     = 3'd2,
    DELIVER = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
  localparam logic [CNT_W-1:0] DEL_LAST  = CNT_W'(DELIVER_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [2:0]       step_q, step_d;
  logic [RND_W-1:0] round_q, round_d;
  logic [RND_W-1:0] rounds_q, rounds_d;
  logic [1:0]       inlet_q, inlet_d;
  logic [1:0]       trap_q, trap_d;
  logic [12:0]      valve_d;
  logic             busy_d, done_d;
  logic [2:0]       pat_idx;

  // Peristaltic pattern as valve bits {cb3_3, cb3_2, cb3_1}.
  function automatic logic [2:0] mix_pat(input logic [2:0] idx);
    case (idx)
      3'd0:    mix_pat = 3'b110;
      3'd1:    mix_pat = 3'b100;
      3'd2:    mix_pat = 3'b101;
      3'd3:    mix_pat = 3'b001;
      3'd4:    mix_pat = 3'b011;
      3'd5:    mix_pat = 3'b010;
      default: mix_pat = 3'b111;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      dwell_q  <= '0;
      step_q   <= '0;
      round_q  <= '0;
      rounds_q <= '0;
      inlet_q  <= '0;
      trap_q   <= '0;
      valve    <= '1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      step_q   <= step_d;
      round_q  <= round_d;
      rounds_q <= rounds_d;
      inlet_q  <= inlet_d;
      trap_q   <= trap_d;
      valve    <= valve_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  assign state_o = state_q;

  // The dwell counter restarts from zero whenever the state or the mix step changes.
  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q + CNT_W'(1);
    step_d   = step_q;
    round_d  = round_q;
    rounds_d = rounds_q;
    inlet_d  = inlet_q;
    trap_d   = trap_q;
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      dwell_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          dwell_d = '0;
          if (start && !abort) begin
            state_d  = FILL;
            inlet_d  = inlet_sel;
            trap_d   = trap_sel;
            rounds_d = mix_rounds;
          end
        end
        FILL: begin
          if (dwell_q == FILL_LAST) begin
            dwell_d = '0;
            step_d  = '0;
            round_d = '0;
            state_d = (rounds_q != '0) ? MIX : DELIVER;
          end
        end
        MIX: begin
          if (dwell_q == STEP_LAST) begin
            dwell_d = '0;
            if (step_q == 3'd5) begin
              step_d = '0;
              if (round_q == rounds_q - RND_W'(1)) state_d = DELIVER;
              else                                  round_d = round_q + RND_W'(1);
            end else begin
              step_d = step_q + 3'd1;
            end
          end
        end
        DELIVER: begin
          if (dwell_q == DEL_LAST) begin
            dwell_d = '0;
            state_d = DONE;
          end
        end
        DONE: begin
          dwell_d = '0;
          state_d = IDLE;
        end
        default: begin
          dwell_d = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    valve_d = '1;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    pat_idx = step_d;
`ifdef MIX_REVERSE_EN
    if (round_d[0]) pat_idx = 3'd5 - step_d;
`endif
    case (state_d)
      FILL: begin
        valve_d[3:0] = {~inlet_d[1], inlet_d[1], ~inlet_d[0], inlet_d[0]};
        valve_d[6:4] = 3'b000;
        valve_d[7]   = 1'b0;
        valve_d[8]   = 1'b1;
      end
      MIX: begin
        valve_d[6:4] = mix_pat(pat_idx);
      end
      DELIVER: begin
        valve_d[6:4]  = 3'b000;
        valve_d[7]    = 1'b1;
        valve_d[8]    = 1'b0;
        valve_d[12:9] = {~trap_d[1], trap_d[1], ~trap_d[0], trap_d[0]};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rotary_cells_valve_seq.sv
// Directed bench for rotary_cells_valve_seq with short dwell times (FILL=4, STEP=2, DELIVER=3).
module tb_rotary_cells_valve_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [1:0]  inlet_sel;
  logic [1:0]  trap_sel;
  logic [7:0]  mix_rounds;
  logic        busy;
  logic        done;
  logic [2:0]  state_o;
  logic [12:0] valve;

  int n_checks = 0;
  int n_fail   = 0;

  logic [12:0] mix_tab [6];

  always #5 clk = ~clk;

  rotary_cells_valve_seq #(
    .FILL_CYC(4), .STEP_CYC(2), .DELIVER_CYC(3), .RND_W(8), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .inlet_sel(inlet_sel), .trap_sel(trap_sel), .mix_rounds(mix_rounds),
    .busy(busy), .done(done), .state_o(state_o), .valve(valve)
  );

  task automatic checkOutput(input string tag, input logic [12:0] v, input logic [2:0] s,
                             input logic b, input logic d);
    n_checks++;
    assert ({valve, state_o, busy, done} === {v, s, b, d}) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed valve=%h state=%0d busy=%b done=%b, expected valve=%h state=%0d busy=%b done=%b",
             tag, valve, state_o, busy, done, v, s, b, d);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start in the current cycle; returns in cycle 1 of the run.
  task automatic applyStimulus(input logic [1:0] in_s, input logic [1:0] tr_s, input int r);
    inlet_sel  = in_s;
    trap_sel   = tr_s;
    mix_rounds = 8'(r);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic runAndCheck(input string tag, input logic [1:0] in_s, input logic [1:0] tr_s,
                             input int r, input logic [12:0] fill_v, input logic [12:0] del_v,
                             input bit pulses);
    int mix_end;
    int del_end;
    int done_c;
    int k;
    int rr;
    int st;
    int idx;
    mix_end = 4 + 12 * r;
    del_end = mix_end + 3;
    done_c  = del_end + 1;
    applyStimulus(in_s, tr_s, r);
    for (int c = 1; c <= done_c + 1; c++) begin
      if (c <= 4) begin
        checkOutput($sformatf("%s_fill_c%0d", tag, c), fill_v, 3'd1, 1'b1, 1'b0);
      end else if (c <= mix_end) begin
        k   = c - 5;
        rr  = k / 12;
        st  = (k % 12) / 2;
        idx = st;
`ifdef MIX_REVERSE_EN
        if (rr % 2 == 1) idx = 5 - st;
`endif
        checkOutput($sformatf("%s_mix_c%0d_r%0d", tag, c, rr), mix_tab[idx], 3'd2, 1'b1, 1'b0);
      end else if (c <= del_end) begin
        checkOutput($sformatf("%s_deliver_c%0d", tag, c), del_v, 3'd3, 1'b1, 1'b0);
      end else if (c == done_c) begin
        checkOutput($sformatf("%s_done_c%0d", tag, c), 13'h1FFF, 3'd4, 1'b1, 1'b1);
      end else begin
        checkOutput($sformatf("%s_idle_c%0d", tag, c), 13'h1FFF, 3'd0, 1'b0, 1'b0);
      end
      if (pulses && (c == 3 || c == done_c)) begin
        start      = 1'b1;
        inlet_sel  = ~in_s;
        trap_sel   = ~tr_s;
        mix_rounds = 8'(r + 3);
      end
      tick();
      start = 1'b0;
    end
  endtask

  initial begin
    mix_tab[0] = 13'h1FEF;
    mix_tab[1] = 13'h1FCF;
    mix_tab[2] = 13'h1FDF;
    mix_tab[3] = 13'h1F9F;
    mix_tab[4] = 13'h1FBF;
    mix_tab[5] = 13'h1FAF;

    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    inlet_sel  = 2'd0;
    trap_sel   = 2'd0;
    mix_rounds = 8'd0;
    #3;
    checkOutput("reset", 13'h1FFF, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("idle_after_reset", 13'h1FFF, 3'd0, 1'b0, 1'b0);

    $display("[TB] run: inlet=2 trap=1 rounds=1 with ignored start pulses");
    runAndCheck("r1", 2'd2, 2'd1, 1, 13'h1F06, 13'h128F, 1'b1);

    $display("[TB] run: inlet=0 trap=3 rounds=0");
    runAndCheck("r0", 2'd0, 2'd3, 0, 13'h1F0A, 13'h0A8F, 1'b0);

    $display("[TB] abort during MIX");
    applyStimulus(2'd3, 2'd0, 1);
    for (int c = 1; c <= 7; c++) begin
      if (c <= 4)      checkOutput($sformatf("ab_fill_c%0d", c), 13'h1F05, 3'd1, 1'b1, 1'b0);
      else if (c <= 6) checkOutput($sformatf("ab_mix_c%0d", c), 13'h1FEF, 3'd2, 1'b1, 1'b0);
      else             checkOutput($sformatf("ab_mix_c%0d", c), 13'h1FCF, 3'd2, 1'b1, 1'b0);
      if (c == 7) abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    for (int c = 8; c <= 12; c++) begin
      checkOutput($sformatf("ab_idle_c%0d", c), 13'h1FFF, 3'd0, 1'b0, 1'b0);
      tick();
    end

    $display("[TB] abort and start together in IDLE");
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("ab_start_idle", 13'h1FFF, 3'd0, 1'b0, 1'b0);
    tick();
    checkOutput("ab_start_idle2", 13'h1FFF, 3'd0, 1'b0, 1'b0);

    $display("[TB] asynchronous reset mid-FILL");
    applyStimulus(2'd2, 2'd1, 1);
    tick();
    checkOutput("rst_fill_c2", 13'h1F06, 3'd1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async", 13'h1FFF, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("rst_release_idle", 13'h1FFF, 3'd0, 1'b0, 1'b0);

    $display("[TB] run: inlet=1 trap=2 rounds=2");
    runAndCheck("r2", 2'd1, 2'd2, 2, 13'h1F09, 13'h0C8F, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
